// File: rtl/tama_pkg.sv
// Shared definitions for the pet UART transmit scheduler: frame layout,
// alarm byte prefix, FSM state encoding and the critical-stat mask helper.
package tama_pkg;
  localparam int STAT_W = 5;
  localparam int FRAME_LEN = 9;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam logic [1:0] ALARM_PREFIX = 2'b11;

  typedef logic [STAT_W-1:0] stat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_ALARM,
    ST_FRAME
  } tx_state_t;

  // Bit order matches the alarm byte and frame byte 7: social in bit 5, hunger in bit 0.
  function automatic logic [5:0] crit_mask(input stat_t hunger, input stat_t happiness,
                                           input stat_t health, input stat_t hygiene,
                                           input stat_t energy, input stat_t social,
                                           input stat_t level);
    return {social <= level, energy <= level, hygiene <= level,
            health <= level, happiness <= level, hunger <= level};
  endfunction
endpackage

// File: rtl/tama_tx_scheduler_if.sv
// Byte-wide valid/ready link from the scheduler to the UART transmitter.
interface tama_tx_scheduler_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/tama_frame_mux.sv
// Status frame builder: snapshots the stats on frame entry and presents the
// byte that follows the one currently on the bus, with a running XOR checksum.
module tama_frame_mux
  import tama_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter logic [4:0] ALARM_LEVEL = 5'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  input  stat_t      hunger,
  input  stat_t      happiness,
  input  stat_t      health,
  input  stat_t      hygiene,
  input  stat_t      energy,
  input  stat_t      social,
  input  logic       is_sleeping,
  output logic [7:0] next_byte,
  output logic       last_byte
);
  stat_t      snap [6];
  logic       snap_sleep;
  logic [3:0] idx;
  logic [7:0] csum;

  assign last_byte = (idx == 4'(FRAME_LEN - 1));

  // idx is the byte currently on the bus; next_byte is byte idx+1.
  always_comb begin
    next_byte = csum;
    if (idx < 4'd6) begin
      next_byte = {3'b000, snap[idx[2:0]]};
    end else if (idx == 4'd6) begin
      next_byte = {snap_sleep, 1'b0,
                   crit_mask(snap[0], snap[1], snap[2], snap[3], snap[4], snap[5], ALARM_LEVEL)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) snap[i] <= '0;
      snap_sleep <= 1'b0;
      idx        <= '0;
      csum       <= '0;
    end else if (start) begin
      snap[0]    <= hunger;
      snap[1]    <= happiness;
      snap[2]    <= health;
      snap[3]    <= hygiene;
      snap[4]    <= energy;
      snap[5]    <= social;
      snap_sleep <= is_sleeping;
      idx        <= '0;
      csum       <= HEADER;
    end else if (advance) begin
      idx  <= idx + 4'd1;
      csum <= csum ^ next_byte;
    end
  end
endmodule

// File: rtl/tama_tx_scheduler.sv
// Arbitrates the single UART TX byte stream between command acks, critical-stat
// alarms and periodic status frames; frames are never interleaved with other bytes.
module tama_tx_scheduler
  import tama_pkg::*;
#(
  parameter logic [3:0] REPORT_PERIOD = 4'd1,
  parameter logic [4:0] ALARM_LEVEL   = 5'd4,
  parameter logic [7:0] HEADER        = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 second,
  input  stat_t                hunger,
  input  stat_t                happiness,
  input  stat_t                health,
  input  stat_t                hygiene,
  input  stat_t                energy,
  input  stat_t                social,
  input  logic                 is_sleeping,
  input  logic                 ack_req,
  input  logic [7:0]           ack_byte,
  tama_tx_scheduler_if.master  tx,
  output logic                 busy,
  output logic                 ack_drop,
  output logic [7:0]           frame_cnt
);
  localparam logic [3:0] PERIOD_EFF = (REPORT_PERIOD == 4'd0) ? 4'd1 : REPORT_PERIOD;

  tx_state_t  state;
  logic       ack_pending, alarm_pending, report_pending;
  logic [7:0] ack_buf;
  logic [3:0] sec_cnt;
  logic [5:0] crit_now, crit_q;
  logic       accept, ack_accept, alarm_accept, frame_done, frame_start, frame_advance;
  logic [7:0] mux_byte;
  logic       mux_last;

  assign crit_now      = crit_mask(hunger, happiness, health, hygiene, energy, social, ALARM_LEVEL);
  assign accept        = tx.tx_valid & tx.tx_ready;
  assign ack_accept    = accept && (state == ST_ACK);
  assign alarm_accept  = accept && (state == ST_ALARM);
  assign frame_done    = accept && (state == ST_FRAME) && mux_last;
  assign frame_advance = accept && (state == ST_FRAME) && !mux_last;
  assign frame_start   = (state == ST_IDLE) && !ack_pending && !alarm_pending && report_pending;
  assign busy          = (state != ST_IDLE) | tx.tx_valid;

  tama_frame_mux #(.HEADER(HEADER), .ALARM_LEVEL(ALARM_LEVEL)) u_frame_mux (
    .clk        (clk),
    .reset      (reset),
    .start      (frame_start),
    .advance    (frame_advance),
    .hunger     (hunger),
    .happiness  (happiness),
    .health     (health),
    .hygiene    (hygiene),
    .energy     (energy),
    .social     (social),
    .is_sleeping(is_sleeping),
    .next_byte  (mux_byte),
    .last_byte  (mux_last)
  );

  // Request side; a new request arriving with its own clear wins, so nothing is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_pending    <= 1'b0;
      ack_buf        <= '0;
      ack_drop       <= 1'b0;
      alarm_pending  <= 1'b0;
      report_pending <= 1'b0;
      sec_cnt        <= '0;
      crit_q         <= '0;
    end else begin
      ack_drop <= 1'b0;
      if (ack_req) begin
        if (!ack_pending || ack_accept) begin
          ack_pending <= 1'b1;
          ack_buf     <= ack_byte;
        end else begin
          ack_drop <= 1'b1;
        end
      end else if (ack_accept) begin
        ack_pending <= 1'b0;
      end

      crit_q <= crit_now;
      if (alarm_accept) alarm_pending <= 1'b0;
      if (|(crit_now & ~crit_q) && !is_sleeping) alarm_pending <= 1'b1;

      if (frame_done) report_pending <= 1'b0;
      if (second) begin
        if (sec_cnt + 4'd1 >= PERIOD_EFF) begin
          sec_cnt        <= '0;
          report_pending <= 1'b1;
        end else begin
          sec_cnt <= sec_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= '0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ack_pending) begin
            tx.tx_data  <= ack_buf;
            tx.tx_valid <= 1'b1;
            state       <= ST_ACK;
          end else if (alarm_pending) begin
            tx.tx_data  <= {ALARM_PREFIX, crit_q};
            tx.tx_valid <= 1'b1;
            state       <= ST_ALARM;
          end else if (report_pending) begin
            tx.tx_data  <= HEADER;
            tx.tx_valid <= 1'b1;
            state       <= ST_FRAME;
          end
        end
        ST_ACK, ST_ALARM: begin
          if (tx.tx_ready) begin
            tx.tx_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_FRAME: begin
          if (tx.tx_ready) begin
            if (mux_last) begin
              tx.tx_valid <= 1'b0;
              state       <= ST_IDLE;
              frame_cnt   <= frame_cnt + 8'd1;
            end else begin
              tx.tx_data <= mux_byte;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tama_tx_scheduler.sv
// Randomised and directed bench for tama_tx_scheduler against a byte-queue
// reference model of the scheduling rules.
module tb_tama_tx_scheduler;
  localparam int PERIOD = 3;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, second, is_sleeping, ack_req;
  logic [7:0] ack_byte;
  logic [4:0] stat_v [6];
  logic [4:0] hunger, happiness, health, hygiene, energy, social;
  logic       busy, ack_drop;
  logic [7:0] frame_cnt;

  tama_tx_scheduler_if tx_bus ();

  assign hunger    = stat_v[0];
  assign happiness = stat_v[1];
  assign health    = stat_v[2];
  assign hygiene   = stat_v[3];
  assign energy    = stat_v[4];
  assign social    = stat_v[5];

  tama_tx_scheduler #(.REPORT_PERIOD(4'(PERIOD)), .ALARM_LEVEL(5'd4), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset), .second(second),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social),
    .is_sleeping(is_sleeping), .ack_req(ack_req), .ack_byte(ack_byte),
    .tx(tx_bus.master), .busy(busy), .ack_drop(ack_drop), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int drops_seen = 0;

  // Reference model: pending requests plus the queue of bytes still to be sent.
  bit         m_ack_full, m_alarm_req, m_report_req, m_sending, m_drop;
  logic [7:0] m_ack_val;
  int         m_sec, m_kind;
  logic [5:0] m_prev_crit;
  logic [7:0] m_frames;
  logic [7:0] m_bytes [$];
  logic [7:0] seen [$];
  logic [7:0] exp_frame [9];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [5:0] critOf();
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = (stat_v[i] <= 5'd4);
    return r;
  endfunction

  task automatic modelReset();
    m_ack_full = 0; m_alarm_req = 0; m_report_req = 0; m_sending = 0; m_drop = 0;
    m_ack_val = '0; m_sec = 0; m_kind = 0; m_prev_crit = '0; m_frames = '0;
    m_bytes.delete();
  endtask

  task automatic modelStep();
    bit acc, ack_acc, alarm_acc, fdone;
    logic [5:0] c;
    logic [7:0] x;
    acc = m_sending && tx_bus.tx_ready;
    ack_acc = acc && m_kind == 0;
    alarm_acc = acc && m_kind == 1;
    fdone = 0;
    c = critOf();
    if (acc) begin
      void'(m_bytes.pop_front());
      if (m_bytes.size() == 0) begin
        m_sending = 0;
        if (m_kind == 2) begin m_frames++; fdone = 1; end
      end
    end else if (!m_sending) begin
      if (m_ack_full) begin
        m_kind = 0; m_bytes.push_back(m_ack_val); m_sending = 1;
      end else if (m_alarm_req) begin
        m_kind = 1; m_bytes.push_back({2'b11, m_prev_crit}); m_sending = 1;
      end else if (m_report_req) begin
        m_kind = 2; m_sending = 1;
        m_bytes.push_back(HDR);
        for (int i = 0; i < 6; i++) m_bytes.push_back({3'b000, stat_v[i]});
        m_bytes.push_back({is_sleeping, 1'b0, c});
        x = 8'h00;
        foreach (m_bytes[i]) x ^= m_bytes[i];
        m_bytes.push_back(x);
      end
    end
    m_drop = 0;
    if (ack_req) begin
      if (!m_ack_full || ack_acc) begin m_ack_full = 1; m_ack_val = ack_byte; end
      else m_drop = 1;
    end else if (ack_acc) m_ack_full = 0;
    if (alarm_acc) m_alarm_req = 0;
    if ((c & ~m_prev_crit) != 0 && !is_sleeping) m_alarm_req = 1;
    m_prev_crit = c;
    if (fdone) m_report_req = 0;
    if (second) begin
      m_sec++;
      if (m_sec >= PERIOD) begin m_sec = 0; m_report_req = 1; end
    end
  endtask

  task automatic compareAll();
    checkOutput("tx_valid", 32'(tx_bus.tx_valid), 32'(m_sending));
    if (m_sending) checkOutput("tx_data", 32'(tx_bus.tx_data), 32'(m_bytes[0]));
    checkOutput("ack_drop", 32'(ack_drop), 32'(m_drop));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    checkOutput("busy", 32'(busy), 32'(m_sending));
  endtask

  task automatic applyStimulus(input bit sec, input bit ackr, input logic [7:0] ackb, input bit rdy);
    second = sec;
    ack_req = ackr;
    ack_byte = ackb;
    tx_bus.tx_ready = rdy;
  endtask

  task automatic stepCycle();
    if (tx_bus.tx_valid && tx_bus.tx_ready) seen.push_back(tx_bus.tx_data);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
    if (ack_drop) drops_seen++;
    compareAll();
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(0, 0, 8'h00, 1);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_tx_valid", 32'(tx_bus.tx_valid), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    compareAll();
    reset = 1'b0;
    seen.delete();
  endtask

  task automatic setStats(input int base);
    for (int i = 0; i < 6; i++) stat_v[i] = 5'(base + i);
  endtask

  task automatic secondPulses(input int gap_rdy_mode);
    for (int p = 0; p < PERIOD; p++) begin
      applyStimulus(1, 0, 8'h00, gap_rdy_mode == 0 ? 1'b1 : (cyc % 3 == 0));
      stepCycle();
      applyStimulus(0, 0, 8'h00, gap_rdy_mode == 0 ? 1'b1 : (cyc % 3 == 0));
      stepCycle();
    end
  endtask

  task automatic runUntilFrames(input logic [7:0] target, input bit stall, input string tag);
    for (int i = 0; i < 300 && m_frames != target; i++) begin
      applyStimulus(0, 0, 8'h00, stall ? (cyc % 3 == 0) : 1'b1);
      stepCycle();
    end
    checkOutput(tag, 32'(frame_cnt), 32'(target));
  endtask

  task automatic drainIdle(input int extra);
    for (int i = 0; i < 300 && (m_sending || m_ack_full || m_alarm_req || m_report_req); i++) begin
      applyStimulus(0, 0, 8'h00, 1);
      stepCycle();
    end
    checkOutput("drain_done", 32'(busy), 32'd0);
    repeat (extra) begin applyStimulus(0, 0, 8'h00, 1); stepCycle(); end
  endtask

  task automatic checkFrameSeen(input string tag);
    checkOutput({tag, "_len"}, 32'(seen.size()), 32'd9);
    for (int i = 0; i < 9 && i < seen.size(); i++)
      checkOutput(tag, 32'(seen[i]), 32'(exp_frame[i]));
  endtask

  initial begin
    exp_frame = '{8'hA5, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h00, 8'hA4};
    reset = 1'b0;
    is_sleeping = 1'b0;
    setStats(20);
    applyStimulus(0, 0, 8'h00, 1);
    doReset();

    // Reference frame with the stats 20..25 and full-rate ready.
    drainIdle(3);
    seen.delete();
    secondPulses(0);
    runUntilFrames(8'd1, 0, "frame1_cnt");
    drainIdle(1);
    checkFrameSeen("frame1_byte");

    // Same frame while the transmitter only accepts one cycle in three.
    seen.delete();
    secondPulses(1);
    runUntilFrames(8'd2, 1, "frame2_cnt");
    drainIdle(1);
    checkFrameSeen("frame2_byte");

    // Acks during a frame: first waits, second is dropped.
    seen.delete();
    drops_seen = 0;
    secondPulses(1);
    for (int i = 0; i < 60 && !(m_sending && m_kind == 2 && m_bytes.size() <= 7); i++) begin
      applyStimulus(0, 0, 8'h00, cyc % 3 == 0);
      stepCycle();
    end
    applyStimulus(0, 1, 8'h3C, 1'b0); stepCycle();
    applyStimulus(0, 0, 8'h00, 1'b0); stepCycle();
    applyStimulus(0, 1, 8'h3D, 1'b0); stepCycle();
    runUntilFrames(8'd3, 1, "frame3_cnt");
    drainIdle(2);
    checkOutput("ack_mid_len", 32'(seen.size()), 32'd10);
    if (seen.size() == 10) checkOutput("ack_mid_byte", 32'(seen[9]), 32'h3C);
    checkOutput("ack_drop_count", 32'(drops_seen), 32'd1);

    // Health becomes critical in the same cycle an ack arrives.
    stat_v[2] = 5'd10;
    drainIdle(2);
    seen.delete();
    stat_v[2] = 5'd3;
    applyStimulus(0, 1, 8'h55, 1); stepCycle();
    drainIdle(3);
    checkOutput("alarm_len", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      checkOutput("alarm_ack_first", 32'(seen[0]), 32'h55);
      checkOutput("alarm_byte", 32'(seen[1]), 32'hC4);
    end

    // Same drop while asleep raises no alarm.
    stat_v[2] = 5'd10;
    drainIdle(2);
    is_sleeping = 1'b1;
    seen.delete();
    stat_v[2] = 5'd3;
    drainIdle(10);
    checkOutput("sleep_no_alarm", 32'(seen.size()), 32'd0);
    stat_v[2] = 5'd10;
    is_sleeping = 1'b0;
    drainIdle(2);

    // Reset in the middle of a frame aborts it for good.
    setStats(20);
    secondPulses(0);
    for (int i = 0; i < 60 && !(m_sending && m_kind == 2 && m_bytes.size() == 4); i++) begin
      applyStimulus(0, 0, 8'h00, 1);
      stepCycle();
    end
    checkOutput("midframe_reached", 32'(m_bytes.size()), 32'd4);
    doReset();
    repeat (20) begin applyStimulus(0, 0, 8'h00, 1); stepCycle(); end
    checkOutput("post_reset_quiet", 32'(seen.size()), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) stat_v[$urandom_range(0, 5)] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 63) == 0) is_sleeping = ~is_sleeping;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                    8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
      stepCycle();
    end
    drainIdle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
